// File: rtl/uc_control.sv
// uc_control: multi-cycle Moore control unit for an RV32I-style core.
// A state register walks FETCH/DECODE/EXECUTE/MEM/WB. The instruction register
// captures the fetched word's opcode at the end of FETCH. Datapath controls are
// decoded purely from the current state.
module uc_control (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instru,
    output logic [6:0]  opcode,
    output logic        PcWrite,
    output logic        IMemRead,
    output logic        AluSrcA,
    output logic [1:0]  AluSrcB,
    output logic        AluFct
);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I_ALU  = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    typedef enum logic [3:0] {
        ST_RST    = 4'd0,
        ST_FETCH  = 4'd1,
        ST_DECODE = 4'd2,
        ST_R_EX   = 4'd3,
        ST_I_EX   = 4'd4,
        ST_ADDR   = 4'd5,
        ST_MEM    = 4'd6,
        ST_BR     = 4'd7,
        ST_WB     = 4'd8
    } state_t;

    state_t     state_r;
    state_t     next_state_s;
    logic [6:0] ir_r;

    // Only the opcode field steers sequencing; the remaining fields are decoded
    // elsewhere in the datapath.
    logic unused_instru_s;
    assign unused_instru_s = ^instru[31:7];

    assign opcode = ir_r;

    // State register and instruction capture; IR is loaded only as FETCH ends.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_RST;
            ir_r    <= 7'd0;
        end else begin
            state_r <= next_state_s;
            if (state_r == ST_FETCH) begin
                ir_r <= instru[6:0];
            end else begin
                ir_r <= ir_r;
            end
        end
    end

    // Next-state sequencing and Moore output decode from the current state.
    always_comb begin
        next_state_s = ST_RST;
        PcWrite      = 1'b0;
        IMemRead     = 1'b0;
        AluSrcA      = 1'b0;
        AluSrcB      = 2'b00;
        AluFct       = 1'b0;
        case (state_r)
            ST_RST: begin
                next_state_s = ST_FETCH;
            end
            ST_FETCH: begin
                PcWrite      = 1'b1;
                IMemRead     = 1'b1;
                AluSrcB      = 2'b01;
                next_state_s = ST_DECODE;
            end
            ST_DECODE: begin
                // Branch target is precomputed here while the opcode is examined.
                AluSrcB = 2'b11;
                case (ir_r)
                    OP_R:      next_state_s = ST_R_EX;
                    OP_I_ALU:  next_state_s = ST_I_EX;
                    OP_LOAD:   next_state_s = ST_ADDR;
                    OP_STORE:  next_state_s = ST_ADDR;
                    OP_BRANCH: next_state_s = ST_BR;
                    default:   next_state_s = ST_FETCH;
                endcase
            end
            ST_R_EX: begin
                AluSrcA      = 1'b1;
                AluFct       = 1'b1;
                next_state_s = ST_WB;
            end
            ST_I_EX: begin
                AluSrcA      = 1'b1;
                AluSrcB      = 2'b10;
                AluFct       = 1'b1;
                next_state_s = ST_WB;
            end
            ST_ADDR: begin
                AluSrcA      = 1'b1;
                AluSrcB      = 2'b10;
                next_state_s = ST_MEM;
            end
            ST_MEM: begin
                if (ir_r == OP_LOAD) begin
                    next_state_s = ST_WB;
                end else begin
                    next_state_s = ST_FETCH;
                end
            end
            ST_BR: begin
                // Taken-branch PC update is handled outside; only the compare runs.
                AluSrcA      = 1'b1;
                AluFct       = 1'b1;
                next_state_s = ST_FETCH;
            end
            ST_WB: begin
                next_state_s = ST_FETCH;
            end
            default: begin
                // Illegal encodings fall back to RST with all controls idle.
                next_state_s = ST_RST;
            end
        endcase
    end

endmodule

// File: tb/tb_uc_control.sv
// Self-checking bench for uc_control: directed vector table, random stimulus
// against an instruction-level reference model, and loop-length sequences.
module tb_uc_control;

    logic        clk;
    logic        reset;
    logic [31:0] instru;
    logic [6:0]  opcode;
    logic        PcWrite;
    logic        IMemRead;
    logic        AluSrcA;
    logic [1:0]  AluSrcB;
    logic        AluFct;

    uc_control dut (
        .clk      (clk),
        .reset    (reset),
        .instru   (instru),
        .opcode   (opcode),
        .PcWrite  (PcWrite),
        .IMemRead (IMemRead),
        .AluSrcA  (AluSrcA),
        .AluSrcB  (AluSrcB),
        .AluFct   (AluFct)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Output word packing: {PcWrite, IMemRead, AluSrcA, AluSrcB[1:0], AluFct}
    localparam logic [5:0] O_IDLE  = 6'b000000; // RST, MEM, WB
    localparam logic [5:0] O_FETCH = 6'b110010;
    localparam logic [5:0] O_DEC   = 6'b000110;
    localparam logic [5:0] O_REX   = 6'b001001;
    localparam logic [5:0] O_IEX   = 6'b001101;
    localparam logic [5:0] O_ADDR  = 6'b001100;
    localparam logic [5:0] O_BR    = 6'b001001;

    int errors = 0;
    int checks = 0;

    // Reference model: queue of output words still to come for the current
    // instruction; an empty queue means the control unit is fetching.
    logic [5:0] exp_q[$];
    logic [6:0] ir_m;

    typedef struct {
        logic        rst;
        logic [31:0] ins;
        logic [5:0]  exp_out;
        logic [6:0]  exp_op;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [5:0] obs();
        return {PcWrite, IMemRead, AluSrcA, AluSrcB, AluFct};
    endfunction

    task automatic push_seq(input logic [6:0] op);
        exp_q.push_back(O_DEC);
        case (op)
            7'b0110011: begin exp_q.push_back(O_REX);  exp_q.push_back(O_IDLE); end
            7'b0010011: begin exp_q.push_back(O_IEX);  exp_q.push_back(O_IDLE); end
            7'b0000011: begin exp_q.push_back(O_ADDR); exp_q.push_back(O_IDLE); exp_q.push_back(O_IDLE); end
            7'b0100011: begin exp_q.push_back(O_ADDR); exp_q.push_back(O_IDLE); end
            7'b1100011: begin exp_q.push_back(O_BR); end
            default: ;
        endcase
    endtask

    task automatic model_edge(input logic r, input logic [31:0] ins);
        if (r) begin
            exp_q.delete();
            exp_q.push_back(O_IDLE);
            ir_m = 7'd0;
        end else if (exp_q.size() == 0) begin
            ir_m = ins[6:0];
            push_seq(ins[6:0]);
        end else begin
            void'(exp_q.pop_front());
        end
    endtask

    function automatic logic [5:0] model_out();
        return (exp_q.size() == 0) ? O_FETCH : exp_q[0];
    endfunction

    task automatic check(input string name, input logic [12:0] act, input logic [12:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got out=%b op=%b, expected out=%b op=%b",
                     name, act[12:7], act[6:0], exp[12:7], exp[6:0]);
        end
    endtask

    // Apply inputs for one cycle, clock it, and land on the falling edge.
    task automatic step(input logic r, input logic [31:0] ins);
        reset  = r;
        instru = ins;
        @(posedge clk);
        model_edge(r, ins);
        @(negedge clk);
    endtask

    task automatic add_vec(input logic r, input logic [31:0] ins,
                           input logic [5:0] eo, input logic [6:0] eop);
        vec_t v;
        v.rst = r; v.ins = ins; v.exp_out = eo; v.exp_op = eop;
        vecs.push_back(v);
    endtask

    // Count cycles from a FETCH to the next FETCH while feeding one instruction.
    task automatic loop_len(input string name, input logic [31:0] ins, input int exp_len);
        int n;
        step(1'b1, 32'h0000_0013);
        step(1'b0, ins);
        check({name, "_first_fetch"}, {obs(), opcode}, {O_FETCH, 7'd0});
        n = 1;
        for (int k = 0; k < 20; k++) begin
            step(1'b0, ins);
            check({name, "_model"}, {obs(), opcode}, {model_out(), ir_m});
            if (obs() == O_FETCH) break;
            n++;
        end
        checks++;
        if (n != exp_len) begin
            errors++;
            $display("FAIL %s_len: got %0d cycles, expected %0d", name, n, exp_len);
        end
    endtask

    logic [6:0] ops[6];

    initial begin
        reset  = 1'b1;
        instru = 32'h0000_0013;
        ir_m   = 7'd0;
        @(negedge clk);

        // Directed table: inputs for the cycle, then outputs after the edge.
        add_vec(1'b1, 32'h0000_0013, O_IDLE,  7'b0000000);
        add_vec(1'b1, 32'h0000_0013, O_IDLE,  7'b0000000);
        add_vec(1'b0, 32'h0000_0013, O_FETCH, 7'b0000000);
        add_vec(1'b0, 32'h0000_0013, O_DEC,   7'b0010011);
        add_vec(1'b0, 32'hFFFF_FFFF, O_IEX,   7'b0010011);
        add_vec(1'b0, 32'h0000_0063, O_IDLE,  7'b0010011);
        add_vec(1'b0, 32'h0000_0003, O_FETCH, 7'b0010011);
        add_vec(1'b0, 32'h0020_81B3, O_DEC,   7'b0110011);
        add_vec(1'b0, 32'h0000_0013, O_REX,   7'b0110011);
        add_vec(1'b0, 32'h0000_0023, O_IDLE,  7'b0110011);
        add_vec(1'b0, 32'hDEAD_BEEF, O_FETCH, 7'b0110011);
        add_vec(1'b0, 32'h0000_A103, O_DEC,   7'b0000011);
        add_vec(1'b0, 32'h0000_0033, O_ADDR,  7'b0000011);
        add_vec(1'b0, 32'h0000_0023, O_IDLE,  7'b0000011);
        add_vec(1'b0, 32'h0000_0063, O_IDLE,  7'b0000011);
        add_vec(1'b0, 32'h1234_5678, O_FETCH, 7'b0000011);
        add_vec(1'b0, 32'h0020_A023, O_DEC,   7'b0100011);
        add_vec(1'b0, 32'h0000_0003, O_ADDR,  7'b0100011);
        add_vec(1'b0, 32'h0000_0003, O_IDLE,  7'b0100011);
        add_vec(1'b0, 32'h0000_0003, O_FETCH, 7'b0100011);
        add_vec(1'b0, 32'h0020_8063, O_DEC,   7'b1100011);
        add_vec(1'b0, 32'h0000_0033, O_BR,    7'b1100011);
        add_vec(1'b0, 32'h0000_0033, O_FETCH, 7'b1100011);
        add_vec(1'b0, 32'h0000_007F, O_DEC,   7'b1111111);
        add_vec(1'b0, 32'h0000_0033, O_FETCH, 7'b1111111);
        add_vec(1'b0, 32'h0000_0013, O_DEC,   7'b0010011);
        add_vec(1'b0, 32'h0000_0013, O_IEX,   7'b0010011);
        add_vec(1'b1, 32'h0000_0013, O_IDLE,  7'b0000000);
        add_vec(1'b0, 32'h0000_0033, O_FETCH, 7'b0000000);
        add_vec(1'b0, 32'h0000_0033, O_DEC,   7'b0110011);

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].rst, vecs[i].ins);
            check($sformatf("vec%0d", i), {obs(), opcode}, {vecs[i].exp_out, vecs[i].exp_op});
        end

        // Multi-cycle loop lengths counted from FETCH.
        loop_len("lw",   32'h0000_A103, 5);
        loop_len("sw",   32'h0020_A023, 4);
        loop_len("beq",  32'h0020_8063, 3);
        loop_len("add",  32'h0020_81B3, 4);
        loop_len("unk",  32'h0000_007F, 2);

        // Random instruction stream with occasional resets, checked every cycle.
        ops[0] = 7'b0110011; ops[1] = 7'b0010011; ops[2] = 7'b0000011;
        ops[3] = 7'b0100011; ops[4] = 7'b1100011; ops[5] = 7'b0000000;
        for (int c = 0; c < 3000; c++) begin
            logic [31:0] w;
            int          sel;
            logic        r;
            w   = $urandom;
            sel = $urandom_range(0, 6);
            if (sel < 6) w[6:0] = ops[sel];
            r = ($urandom_range(0, 39) == 0);
            step(r, w);
            check($sformatf("rand%0d", c), {obs(), opcode}, {model_out(), ir_m});
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
